// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write-only target receiver.
//   i2c_rx_state_e : receiver FSM states
//   I2C_ADDR_W     : width of a 7-bit target address
//   I2C_BYTE_W     : width of one bus byte
//   I2C_RW_WRITE   : value of the R/W bit for a write transfer
//   SSD1306_ADDR   : default 7-bit address of the OLED controller
package i2c_pkg;

    localparam int                    I2C_ADDR_W   = 7;
    localparam int                    I2C_BYTE_W   = 8;
    localparam logic                  I2C_RW_WRITE = 1'b0;
    localparam logic [I2C_ADDR_W-1:0] SSD1306_ADDR = 7'h3C;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        DATA_NACK,
        IGNORE
    } i2c_rx_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioning for one raw bus line (SCL or SDA).
// Two-flop synchroniser, then a debouncer: the filtered level only takes a
// new value after the synchronised input has held it for FILT_LEN
// consecutive clk cycles. rise/fall are one-cycle pulses registered in the
// same cycle as the filtered level changes.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (all levels reset to 1)
//   line_in in  raw asynchronous line
//   level   out filtered line level
//   rise    out one-cycle pulse on filtered 0->1
//   fall    out one-cycle pulse on filtered 1->0
module i2c_line_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILT_LEN - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt is a down-counter of the remaining cycles the new level must hold;
    // any cycle where the input agrees with the filtered level reloads it.
    always_comb begin
        sync1_d = line_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = CNT_LOAD;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == '0) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= CNT_LOAD;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver / bus monitor for the SSD1306 link.
// Filters SCL/SDA, decodes START/STOP, matches TARGET_ADDR on writes,
// ACKs the address and each accepted byte, and hands bytes to a sink.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   scl_in   in  raw SCL
//   sda_in   in  raw SDA
//   sda_oe   out 1 = pull SDA low
//   rx_data  out last accepted data byte
//   rx_valid out one-cycle pulse, rx_data newly valid
//   rx_first out with rx_valid: first data byte after the address
//   rx_ready in  sink can take a byte (sampled when a byte completes)
//   busy     out addressed transfer in progress
//   overrun  out sticky, a byte was dropped because rx_ready was 0
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for START
// ADDR      | shifting address + R/W bit
// ADDR_ACK  | driving address ACK (sda_oe marks which SCL fall is next)
// DATA      | shifting a data byte
// DATA_ACK  | driving data ACK, then back to DATA
// DATA_NACK | byte dropped, SDA released through 9th clock
// IGNORE    | not addressed; wait for START/STOP
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = SSD1306_ADDR,
    parameter int                    FILT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_first,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  overrun
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (scl_in),
        .level   (scl_lvl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (sda_in),
        .level   (sda_lvl),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    logic start_det, stop_det;
    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_rx_state_e           state_q, state_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    // Only 7 bits need storing: the 8th bit is taken straight off the line.
    logic [I2C_BYTE_W-2:0]   shift_q, shift_d;
    logic                    sda_oe_q, sda_oe_d;
    logic [I2C_BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_first_q, rx_first_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    first_q, first_d;
    logic                    nack_phase_q, nack_phase_d;

    logic [I2C_BYTE_W-1:0]   byte_next;
    logic                    last_bit;

    assign byte_next = {shift_q, sda_lvl};
    assign last_bit  = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_first_d   = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;
        first_d      = first_q;
        nack_phase_d = nack_phase_q;

        if (start_det) begin
            state_d      = ADDR;
            bit_cnt_d    = 3'd0;
            shift_d      = '0;
            overrun_d    = 1'b0;
            busy_d       = 1'b0;
            sda_oe_d     = 1'b0;
            nack_phase_d = 1'b0;
        end else if (stop_det) begin
            state_d      = IDLE;
            sda_oe_d     = 1'b0;
            busy_d       = 1'b0;
            nack_phase_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_next[I2C_BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (byte_next[I2C_BYTE_W-1:1] == TARGET_ADDR &&
                                byte_next[0] == I2C_RW_WRITE) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // First SCL fall ends bit 8 and starts driving the ACK;
                    // the next fall ends the ACK clock.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = DATA;
                            if (state_q == ADDR_ACK) begin
                                busy_d  = 1'b1;
                                first_d = 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_next[I2C_BYTE_W-2:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (rx_ready) begin
                                rx_data_d  = byte_next;
                                rx_valid_d = 1'b1;
                                rx_first_d = first_q;
                                first_d    = 1'b0;
                                state_d    = DATA_ACK;
                            end else begin
                                overrun_d = 1'b1;
                                state_d   = DATA_NACK;
                            end
                        end
                    end
                end
                DATA_NACK: begin
                    if (scl_fall) begin
                        if (!nack_phase_q) begin
                            nack_phase_d = 1'b1;
                        end else begin
                            nack_phase_d = 1'b0;
                            state_d      = IGNORE;
                        end
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= '0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            first_q      <= 1'b0;
            nack_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            first_q      <= first_d;
            nack_phase_q <= nack_phase_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: a bit-banged bus master plus a transaction-level
// model of what the target should acknowledge and report.
module tb_i2c_target_rx;

    localparam int         FILT  = 4;
    localparam int         Q     = 10;
    localparam logic [6:0] TADDR = 7'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_ready = 1'b1;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, busy, overrun;
    wire        sda_line = sda_m & ~sda_oe;

    i2c_target_rx #(.TARGET_ADDR(TADDR), .FILT_LEN(FILT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .rx_ready (rx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic       first;
        logic [7:0] data;
    } rx_ev_t;

    rx_ev_t rx_q[$];
    int     cyc = 0;
    int     rise8_cyc = 0;
    int     lat_last = 0;
    int     oe_seen = 0;
    int     first_bad = 0;
    int     oe_hi_viol = 0;
    logic   prev_oe = 1'b0;
    logic   prev_rst = 1'b0;
    bit     glitch_en = 1'b0;
    logic [7:0] last_data = 8'h00;

    logic [7:0] tx_data[$];
    bit         tx_ready[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back({rx_first, rx_data});
            lat_last = cyc - rise8_cyc;
        end
        if (!rx_valid && rx_first) first_bad++;
        if (sda_oe) oe_seen++;
        if (rst_n && prev_rst && (sda_oe !== prev_oe) && scl_m) oe_hi_viol++;
        prev_oe  = sda_oe;
        prev_rst = rst_n;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // Optional 2-cycle glitches: SCL high while low, SDA inverted while SCL high.
    task automatic send_bit(input logic b, input bit mark);
        sda_m = b;
        if (glitch_en) begin
            wait_clk(3); scl_m = 1'b1; wait_clk(2); scl_m = 1'b0; wait_clk(Q - 5);
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b1;
        if (mark) rise8_cyc = cyc;
        if (glitch_en) begin
            wait_clk(Q); sda_m = ~b; wait_clk(2); sda_m = b; wait_clk(Q - 2);
        end else begin
            wait_clk(2 * Q);
        end
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic get_ack(output bit ack);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack = ~sda_line;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0);
        get_ack(ack);
    endtask

    // Transaction-level expectation: address ACKed only for our address on a
    // write; each byte is accepted while the sink is ready, the first refused
    // byte sets overrun and everything after it is NACKed.
    task automatic xfer(input string tag, input logic [6:0] addr, input bit rw, input bit do_stop);
        bit     ack;
        bit     exp_addr_ack;
        bit     live;
        bit     first;
        bit     exp_ovr;
        bit     exp_ack;
        rx_ev_t exp_rx[$];
        int     n;

        exp_addr_ack = (addr == TADDR) && !rw;
        live         = exp_addr_ack;
        first        = 1'b1;
        exp_ovr      = 1'b0;

        rx_q.delete();
        oe_seen = 0;
        i2c_start();
        chk({tag, "_ovr_clr"}, overrun, 1'b0);
        send_byte({addr, rw}, ack);
        chk({tag, "_addr_ack"}, ack, exp_addr_ack);
        chk({tag, "_busy"}, busy, exp_addr_ack);

        foreach (tx_data[i]) begin
            rx_ready = tx_ready[i];
            exp_ack  = 1'b0;
            if (live) begin
                if (tx_ready[i]) begin
                    exp_rx.push_back({first, tx_data[i]});
                    first     = 1'b0;
                    last_data = tx_data[i];
                    exp_ack   = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                    live    = 1'b0;
                end
            end
            send_byte(tx_data[i], ack);
            chk({tag, "_data_ack"}, ack, exp_ack);
        end
        rx_ready = 1'b1;

        chk({tag, "_rx_count"}, rx_q.size(), exp_rx.size());
        n = (rx_q.size() < exp_rx.size()) ? rx_q.size() : exp_rx.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_rx_data"}, rx_q[i].data, exp_rx[i].data);
            chk({tag, "_rx_first"}, rx_q[i].first, exp_rx[i].first);
        end
        chk({tag, "_rx_hold"}, rx_data, last_data);
        chk({tag, "_overrun"}, overrun, exp_ovr);
        if (!exp_addr_ack) chk({tag, "_oe_quiet"}, oe_seen != 0, 1'b0);

        if (do_stop) begin
            i2c_stop();
            chk({tag, "_busy_stop"}, busy, 1'b0);
            chk({tag, "_ovr_sticky"}, overrun, exp_ovr);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bit ack;

        wait_clk(3);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_first", rx_first, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        wait_clk(Q);

        tx_data = {8'h00, 8'hAF}; tx_ready = {1'b1, 1'b1};
        xfer("oled_wr", 7'h3C, 1'b0, 1'b1);
        chk("latency", lat_last, FILT + 3);

        tx_data = {8'h12}; tx_ready = {1'b1};
        xfer("wrong_addr", 7'h3D, 1'b0, 1'b1);

        tx_data = {8'h34}; tx_ready = {1'b1};
        xfer("read_req", 7'h3C, 1'b1, 1'b1);

        tx_data = {8'h40}; tx_ready = {1'b0};
        xfer("overrun", 7'h3C, 1'b0, 1'b0);
        tx_data = {8'h11}; tx_ready = {1'b1};
        xfer("rs_after_ovr", 7'h3C, 1'b0, 1'b0);
        tx_data = {8'h55}; tx_ready = {1'b1};
        xfer("rs_first", 7'h3C, 1'b0, 1'b1);

        glitch_en = 1'b1;
        tx_data = {8'hC3, 8'h5A}; tx_ready = {1'b1, 1'b1};
        xfer("glitch", 7'h3C, 1'b0, 1'b1);
        glitch_en = 1'b0;

        // Reset while the target is driving the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : TADDR[i-1], 1'b0);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q / 2);
        chk("ack_before_rst", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("oe_rst_async", sda_oe, 1'b0);
        last_data = 8'h00;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(Q / 2);
        scl_m = 1'b0; wait_clk(Q);
        rx_q.delete();
        send_byte(8'hA5, ack);
        chk("no_start_ack", ack, 1'b0);
        chk("no_start_rx", rx_q.size(), 0);
        i2c_stop();

        for (int t = 0; t < 20; t++) begin
            logic [6:0] a;
            bit         rw;
            int         nb;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TADDR;
            rw = ($urandom_range(0, 4) == 0);
            nb = $urandom_range(1, 3);
            tx_data.delete(); tx_ready.delete();
            for (int k = 0; k < nb; k++) begin
                tx_data.push_back(8'($urandom));
                tx_ready.push_back($urandom_range(0, 5) != 0);
            end
            xfer("rand", a, rw, $urandom_range(0, 1) == 1);
        end
        i2c_stop();

        chk("rx_first_stray", first_bad, 0);
        chk("oe_change_scl_hi", oe_hi_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
